sctag_stdata_stage: RTL and testbench

SCTAG_STDATA_STAGE -- requirements
Module: sctag_stdata_stage

---
 rtl/sctag_stdata_stage.sv | 122 ++++++++++++
 tb/tb_sctag_stdata_stage.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/sctag_stdata_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sctag_stdata_stage: 2-entry store-data FIFO that ECC-encodes each 32-bit     |
// | word at push. Define SCTAG_STDATA_ECC_EN to enable encoding (else ecc=0).  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sctag_stdata_stage (
  input  logic        rclk,
  input  logic        arst_l,
  input  logic        stdata_vld_c1,
  input  logic [63:0] stdata_c1,
  output logic        stdata_rdy_c1,
  output logic        arbdp_store_data_vld_c2,
  output logic [77:0] arbdp_store_data_c2,
  input  logic        stdata_pop_c2,
  output logic        stdata_ovf_err
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic        rdy_q, rdy_d;
  logic        ovf_q, ovf_d;
  logic [77:0] mem0_q, mem0_d;
  logic [77:0] mem1_q, mem1_d;

  logic        push;
  logic        pop;
  logic [6:0]  ecc_hi;
  logic [6:0]  ecc_lo;
  logic [77:0] beat;

`ifdef SCTAG_STDATA_ECC_EN
  // Data bit k sits at the k-th non-power-of-two codeword position (3,5,6,7,9..38).
  function automatic logic [6:0] ecc_enc(input logic [31:0] d);
    logic [5:0] c;
    logic [5:0] pos;
    logic [4:0] k;
    c = 6'd0;
    k = 5'd0;
    for (pos = 6'd3; pos <= 6'd38; pos = pos + 6'd1) begin
      if ((pos & (pos - 6'd1)) != 6'd0) begin
        c = c ^ ({6{d[k]}} & pos);
        k = k + 5'd1;
      end
    end
    return {(^d) ^ (^c), c};
  endfunction

  assign ecc_hi = ecc_enc(stdata_c1[63:32]);
  assign ecc_lo = ecc_enc(stdata_c1[31:0]);
`else
  assign ecc_hi = 7'h00;
  assign ecc_lo = 7'h00;
`endif

  assign beat = {stdata_c1[63:32], ecc_hi, stdata_c1[31:0], ecc_lo};

  always_comb begin
    push = stdata_vld_c1 & rdy_q;
    pop  = stdata_pop_c2 & (state_q != ST_EMPTY);
  end

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      state_q  <= ST_EMPTY;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      rdy_q    <= 1'b1;
      ovf_q    <= 1'b0;
      mem0_q   <= '0;
      mem1_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      rdy_q    <= rdy_d;
      ovf_q    <= ovf_d;
      mem0_q   <= mem0_d;
      mem1_q   <= mem1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (push) state_d = ST_ONE;
      ST_ONE: begin
        if (push && !pop)      state_d = ST_FULL;
        else if (!push && pop) state_d = ST_EMPTY;
      end
      ST_FULL:  if (pop) state_d = ST_ONE;
      default:  state_d = ST_EMPTY;
    endcase
  end

  // rdy is registered from the next state so the consumer's pop never reaches it combinationally.
  always_comb begin
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    mem0_d   = (push && !wr_ptr_q) ? beat : mem0_q;
    mem1_d   = (push &&  wr_ptr_q) ? beat : mem1_q;
    rdy_d    = (state_d != ST_FULL);
    ovf_d    = ovf_q | (stdata_vld_c1 & (state_q == ST_FULL) & ~stdata_pop_c2);
  end

  always_comb begin
    stdata_rdy_c1           = rdy_q;
    stdata_ovf_err          = ovf_q;
    arbdp_store_data_vld_c2 = (state_q != ST_EMPTY);
    arbdp_store_data_c2     = '0;
    if (state_q != ST_EMPTY) begin
      arbdp_store_data_c2 = rd_ptr_q ? mem1_q : mem0_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sctag_stdata_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sctag_stdata_stage: directed vector table, corner sequences and random  |
// | traffic against a queue-based reference model.                            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_sctag_stdata_stage;

  logic        rclk = 1'b0;
  logic        arst_l = 1'b0;
  logic        stdata_vld_c1 = 1'b0;
  logic [63:0] stdata_c1 = 64'h0;
  logic        stdata_pop_c2 = 1'b0;
  logic        stdata_rdy_c1;
  logic        arbdp_store_data_vld_c2;
  logic [77:0] arbdp_store_data_c2;
  logic        stdata_ovf_err;

  int total = 0;
  int bad   = 0;

`ifdef SCTAG_STDATA_ECC_EN
  localparam logic [6:0] E1 = 7'h43;
`else
  localparam logic [6:0] E1 = 7'h00;
`endif

  sctag_stdata_stage dut (
    .rclk                    (rclk),
    .arst_l                  (arst_l),
    .stdata_vld_c1           (stdata_vld_c1),
    .stdata_c1               (stdata_c1),
    .stdata_rdy_c1           (stdata_rdy_c1),
    .arbdp_store_data_vld_c2 (arbdp_store_data_vld_c2),
    .arbdp_store_data_c2     (arbdp_store_data_c2),
    .stdata_pop_c2           (stdata_pop_c2),
    .stdata_ovf_err          (stdata_ovf_err)
  );

  always #5 rclk = ~rclk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Reference model: FIFO contents as a queue of encoded beats plus a sticky error bit.
  logic [77:0] mq[$];
  logic        movf = 1'b0;

  function automatic logic [6:0] ref_ecc(input logic [31:0] w);
`ifdef SCTAG_STDATA_ECC_EN
    int pos_of[32];
    int n;
    logic [6:0] e;
    n = 0;
    for (int p = 1; n < 32; p++) begin
      if ((p & (p - 1)) != 0) begin
        pos_of[n] = p;
        n++;
      end
    end
    e = 7'h00;
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 32; k++) begin
        if (((pos_of[k] >> i) & 1) == 1) e[i] = e[i] ^ w[k];
      end
    end
    e[6] = (^w) ^ (^e[5:0]);
    return e;
`else
    return (w == 32'h0) ? 7'h00 : 7'h00;
`endif
  endfunction

  function automatic logic [77:0] enc(input logic [63:0] d);
    return {d[63:32], ref_ecc(d[63:32]), d[31:0], ref_ecc(d[31:0])};
  endfunction

  task automatic check(input string name, input logic [77:0] got, input logic [77:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [63:0] d, input logic p);
    logic full;
    stdata_vld_c1 = v;
    stdata_c1     = d;
    stdata_pop_c2 = p;
    @(posedge rclk);
    full = (mq.size() == 2);
    if (v && full && !p) movf = 1'b1;
    if (p && mq.size() > 0) void'(mq.pop_front());
    if (v && !full) mq.push_back(enc(d));
    #1;
  endtask

  task automatic check_model(input string tag);
    logic [77:0] exp_data;
    exp_data = (mq.size() != 0) ? mq[0] : 78'h0;
    check({tag, "_vld"},  78'(arbdp_store_data_vld_c2), 78'(mq.size() != 0));
    check({tag, "_data"}, arbdp_store_data_c2, exp_data);
    check({tag, "_rdy"},  78'(stdata_rdy_c1), 78'(mq.size() != 2));
    check({tag, "_ovf"},  78'(stdata_ovf_err), 78'(movf));
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_vld"},  78'(arbdp_store_data_vld_c2), 78'h0);
    check({tag, "_data"}, arbdp_store_data_c2, 78'h0);
    check({tag, "_rdy"},  78'(stdata_rdy_c1), 78'h1);
    check({tag, "_ovf"},  78'(stdata_ovf_err), 78'h0);
  endtask

  typedef struct {
    logic        vld;
    logic [63:0] data;
    logic        pop;
    logic        exp_vld;
    logic [77:0] exp_data;
    logic        exp_rdy;
    logic        exp_ovf;
  } vec_t;

  vec_t tbl[12];

  initial begin
    logic [63:0] a, b, c;
    logic [77:0] enc_a, enc_b, enc_one;
    logic [63:0] bs[6];
    logic [77:0] obs[$];
    logic [63:0] rd;

    a       = 64'h0000_0001_0000_0000;
    b       = 64'h0000_0001_0000_0001;
    c       = 64'hDEAD_BEEF_0BAD_F00D;
    enc_a   = {32'h1, E1, 32'h0, 7'h00};
    enc_b   = {32'h1, E1, 32'h1, E1};
    enc_one = {32'h0, 7'h00, 32'h1, E1};

    tbl[0]  = '{1'b1, 64'h0, 1'b0, 1'b1, 78'h0,   1'b1, 1'b0};
    tbl[1]  = '{1'b0, 64'h0, 1'b0, 1'b1, 78'h0,   1'b1, 1'b0};
    tbl[2]  = '{1'b0, 64'h0, 1'b1, 1'b0, 78'h0,   1'b1, 1'b0};
    tbl[3]  = '{1'b1, 64'h1, 1'b0, 1'b1, enc_one, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 64'h0, 1'b1, 1'b0, 78'h0,   1'b1, 1'b0};
    tbl[5]  = '{1'b0, 64'h0, 1'b1, 1'b0, 78'h0,   1'b1, 1'b0};
    tbl[6]  = '{1'b1, a,     1'b0, 1'b1, enc_a,   1'b1, 1'b0};
    tbl[7]  = '{1'b1, b,     1'b0, 1'b1, enc_a,   1'b0, 1'b0};
    tbl[8]  = '{1'b1, c,     1'b0, 1'b1, enc_a,   1'b0, 1'b1};
    tbl[9]  = '{1'b0, 64'h0, 1'b1, 1'b1, enc_b,   1'b1, 1'b1};
    tbl[10] = '{1'b1, a,     1'b1, 1'b1, enc_a,   1'b1, 1'b1};
    tbl[11] = '{1'b0, 64'h0, 1'b1, 1'b0, 78'h0,   1'b1, 1'b1};

    repeat (2) @(posedge rclk);
    #1;
    check_reset("in_reset");
    #3 arst_l = 1'b1;

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].vld, tbl[i].data, tbl[i].pop);
      check($sformatf("row%0d_vld", i),  78'(arbdp_store_data_vld_c2), 78'(tbl[i].exp_vld));
      check($sformatf("row%0d_data", i), arbdp_store_data_c2, tbl[i].exp_data);
      check($sformatf("row%0d_rdy", i),  78'(stdata_rdy_c1), 78'(tbl[i].exp_rdy));
      check($sformatf("row%0d_ovf", i),  78'(stdata_ovf_err), 78'(tbl[i].exp_ovf));
    end

    // Reset pulse between edges while full with the error flag set.
    drive(1'b1, a, 1'b0);
    drive(1'b1, b, 1'b0);
    drive(1'b1, c, 1'b0);
    check_model("prefull");
    #3 arst_l = 1'b0;
    #1;
    check_reset("midreset");
    mq.delete();
    movf = 1'b0;
    #1 arst_l = 1'b1;
    drive(1'b1, 64'h1234_5678_9ABC_DEF0, 1'b0);
    check("postrst_data", arbdp_store_data_c2, enc(64'h1234_5678_9ABC_DEF0));
    check_model("postrst");
    drive(1'b0, 64'h0, 1'b1);
    check_model("postrst_drain");

    // Six-beat stream with pop asserted every cycle.
    for (int i = 0; i < 6; i++) bs[i] = {$urandom, $urandom};
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, bs[i], 1'b1);
      check_model($sformatf("stream%0d", i));
      if (arbdp_store_data_vld_c2) obs.push_back(arbdp_store_data_c2);
    end
    drive(1'b0, 64'h0, 1'b1);
    check_model("stream_end");
    check("stream_count", 78'(obs.size()), 78'd6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("stream_order%0d", i),
            (i < obs.size()) ? obs[i] : 78'h0, enc(bs[i]));
    end

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      rd = {$urandom, $urandom};
      drive(($urandom % 4) != 0, rd, ($urandom % 2) == 1);
      check_model($sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
